// File: rtl/indexed_bit_reg_if.sv
// Bus bundle for indexed_bit_reg: bit write, shift/rotate control, indexed read
// and the registered state outputs.
interface indexed_bit_reg_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
);
  logic             wr_en;
  logic [IDX_W-1:0] wr_index;
  logic             wr_data;
  logic             shift_en;
  logic             shift_dir;
  logic             shift_in;
  logic [IDX_W-1:0] rd_index;
  logic             O;
  logic [WIDTH-1:0] value;
  logic [IDX_W:0]   ones;

  modport master (
    output wr_en, wr_index, wr_data, shift_en, shift_dir, shift_in, rd_index,
    input  O, value, ones
  );

  modport slave (
    input  wr_en, wr_index, wr_data, shift_en, shift_dir, shift_in, rd_index,
    output O, value, ones
  );
endinterface

// File: rtl/indexed_bit_reg.sv
// Bit-addressable state register with shift/rotate, combinational indexed read
// and a registered population count that tracks the register contents.
module indexed_bit_reg #(
  parameter int               WIDTH  = 8,
  parameter int               IDX_W  = 3,
  parameter logic [WIDTH-1:0] INIT   = 8'hFE,
  parameter int               ROTATE = 0
) (
  input logic          CLK,
  input logic          RESET,
  indexed_bit_reg_if.slave bus
);

  localparam logic [IDX_W:0] LIMIT = (IDX_W+1)'(WIDTH);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] s_next;
  logic [IDX_W:0]   ones_q;
  logic             fill_left;
  logic             fill_right;

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt = cnt + (IDX_W+1)'(v[i]);
    end
    return cnt;
  endfunction

  always_comb begin
    fill_left  = (ROTATE != 0) ? s[WIDTH-1] : bus.shift_in;
    fill_right = (ROTATE != 0) ? s[0]       : bus.shift_in;
  end

  // Write lands on top of the shifted value, so a same-cycle write wins its bit.
  always_comb begin
    shifted = s;
    if (bus.shift_en) begin
      if (!bus.shift_dir) begin
        shifted = {s[WIDTH-2:0], fill_left};
      end else begin
        shifted = {fill_right, s[WIDTH-1:1]};
      end
    end
    s_next = shifted;
    if (bus.wr_en && ({1'b0, bus.wr_index} < LIMIT)) begin
      s_next[bus.wr_index] = bus.wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s      <= INIT;
      ones_q <= popcount(INIT);
    end else begin
      s      <= s_next;
      ones_q <= popcount(s_next);
    end
  end

  assign bus.O     = ({1'b0, bus.rd_index} < LIMIT) ? s[bus.rd_index] : 1'b0;
  assign bus.value = s;
  assign bus.ones  = ones_q;

endmodule

// File: tb/tb_indexed_bit_reg.sv
// Bench for indexed_bit_reg: three configurations driven in lockstep and
// compared against an arithmetic reference model.
module tb_indexed_bit_reg;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  indexed_bit_reg_if #(.WIDTH(8), .IDX_W(3)) b0 ();
  indexed_bit_reg_if #(.WIDTH(8), .IDX_W(3)) b1 ();
  indexed_bit_reg_if #(.WIDTH(6), .IDX_W(3)) b2 ();

  indexed_bit_reg #(.WIDTH(8), .IDX_W(3), .INIT(8'hFE), .ROTATE(0))
    u0 (.CLK(CLK), .RESET(RESET), .bus(b0.slave));
  indexed_bit_reg #(.WIDTH(8), .IDX_W(3), .INIT(8'hFE), .ROTATE(1))
    u1 (.CLK(CLK), .RESET(RESET), .bus(b1.slave));
  indexed_bit_reg #(.WIDTH(6), .IDX_W(3), .INIT(6'h2A), .ROTATE(0))
    u2 (.CLK(CLK), .RESET(RESET), .bus(b2.slave));

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  int          w_cfg[3]    = '{8, 8, 6};
  bit          rot_cfg[3]  = '{1'b0, 1'b1, 1'b0};
  int unsigned init_cfg[3] = '{32'hFE, 32'hFE, 32'h2A};
  int unsigned m[3];

  bit          c_rst, c_we, c_wd, c_se, c_sd, c_si;
  int unsigned c_wi, c_ri;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned model_next(input int k);
    int unsigned cur, mask, fill;
    int          w;
    w    = w_cfg[k];
    mask = (32'd1 << w) - 1;
    if (c_rst) return init_cfg[k];
    cur = m[k];
    if (c_se) begin
      if (!c_sd) begin
        fill = rot_cfg[k] ? ((cur >> (w - 1)) & 1) : 32'(c_si);
        cur  = ((cur << 1) | fill) & mask;
      end else begin
        fill = rot_cfg[k] ? (cur & 1) : 32'(c_si);
        cur  = (cur >> 1) | (fill << (w - 1));
      end
    end
    if (c_we && c_wi < 32'(w)) begin
      cur = (cur & ~(32'd1 << c_wi)) | (32'(c_wd) << c_wi);
    end
    return cur & mask;
  endfunction

  task automatic drive(input bit rst, input bit we, input int unsigned wi, input bit wd,
                       input bit se, input bit sd, input bit si, input int unsigned ri);
    c_rst = rst; c_we = we; c_wi = wi; c_wd = wd;
    c_se = se; c_sd = sd; c_si = si; c_ri = ri;
    RESET = rst;
    b0.wr_en = we; b0.wr_index = 3'(wi); b0.wr_data = wd;
    b0.shift_en = se; b0.shift_dir = sd; b0.shift_in = si; b0.rd_index = 3'(ri);
    b1.wr_en = we; b1.wr_index = 3'(wi); b1.wr_data = wd;
    b1.shift_en = se; b1.shift_dir = sd; b1.shift_in = si; b1.rd_index = 3'(ri);
    b2.wr_en = we; b2.wr_index = 3'(wi); b2.wr_data = wd;
    b2.shift_en = se; b2.shift_dir = sd; b2.shift_in = si; b2.rd_index = 3'(ri);
  endtask

  task automatic check_all();
    logic [31:0] val[3], o[3], on[3];
    int unsigned exp_o;
    val[0] = 32'(b0.value); o[0] = 32'(b0.O); on[0] = 32'(b0.ones);
    val[1] = 32'(b1.value); o[1] = 32'(b1.O); on[1] = 32'(b1.ones);
    val[2] = 32'(b2.value); o[2] = 32'(b2.O); on[2] = 32'(b2.ones);
    for (int k = 0; k < 3; k++) begin
      exp_o = (c_ri < 32'(w_cfg[k])) ? ((m[k] >> c_ri) & 1) : 0;
      check_eq($sformatf("d%0d_value", k), val[k], m[k]);
      check_eq($sformatf("d%0d_O_rd%0d", k, c_ri), o[k], exp_o);
      check_eq($sformatf("d%0d_ones", k), on[k], 32'($countones(m[k])));
    end
  endtask

  task automatic step(input bit rst, input bit we, input int unsigned wi, input bit wd,
                      input bit se, input bit sd, input bit si, input int unsigned ri);
    drive(rst, we, wi, wd, se, sd, si, ri);
    #1;
    check_all();
    @(posedge CLK);
    for (int k = 0; k < 3; k++) m[k] = model_next(k);
    @(negedge CLK);
  endtask

  initial begin
    drive(1, 1, 0, 1, 1, 0, 1, 0);
    @(posedge CLK);
    for (int k = 0; k < 3; k++) m[k] = init_cfg[k];
    @(negedge CLK);

    // Reset values and combinational read.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_eq("rst_o_rd0", 32'(b0.O), 0);
    check_eq("rst_value", 32'(b0.value), 32'hFE);
    check_eq("rst_ones", 32'(b0.ones), 7);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    check_eq("rst_o_rd1", 32'(b0.O), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 6);
    #1;
    check_eq("w6_o_rd6", 32'(b2.O), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 7);
    #1;
    check_eq("w6_o_rd7", 32'(b2.O), 0);

    // Single-bit writes.
    step(0, 1, 0, 1, 0, 0, 0, 0);
    check_eq("wr0_value", 32'(b0.value), 32'hFF);
    check_eq("wr0_ones", 32'(b0.ones), 8);
    check_eq("w6_wr0_value", 32'(b2.value), 32'h2B);
    step(0, 1, 7, 0, 0, 0, 0, 7);
    check_eq("wr7_value", 32'(b0.value), 32'h7F);

    // Shift vs rotate, both directions.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    check_eq("shl_value", 32'(b0.value), 32'hFC);
    check_eq("rotl_value", 32'(b1.value), 32'hFD);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1, 0);
    check_eq("shr_value", 32'(b0.value), 32'hFF);
    check_eq("rotr_value", 32'(b1.value), 32'h7F);

    // Shift plus write in the same cycle, then reset overriding both.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0, 0, 0);
    check_eq("shl_wr_value", 32'(b0.value), 32'hFD);
    step(1, 1, 0, 1, 1, 0, 0, 0);
    check_eq("rst_strobes_value", 32'(b0.value), 32'hFE);

    // Out-of-range write on the narrow instance.
    step(0, 1, 7, 1, 0, 0, 0, 0);
    check_eq("w6_oor_value", 32'(b2.value), 32'h2A);
    check_eq("w6_oor_ones", 32'(b2.ones), 3);

    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 99) < 3), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_all();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/indexed_bit_reg.md
INDEXED_BIT_REG -- requirements
Module: indexed_bit_reg

Interface
REQ-001: Parameter WIDTH, default 8; number of bits in the state register, SHALL be >= 2.
REQ-002: Parameter IDX_W, default 3; index width, SHALL equal ceil(log2(WIDTH)).
REQ-003: Parameter INIT, default 8'hFE; WIDTH-bit reset value of the state register.
REQ-004: Parameter ROTATE, default 0; 0 = shift with shift_in fill, 1 = rotate (shift_in ignored).
REQ-005: CLK  input  1  clock; all state updates on rising edge.
REQ-006: RESET  input  1  synchronous, active-high reset.
REQ-007: wr_en  input  1  single-bit write strobe.
REQ-008: wr_index  input  IDX_W  bit position to write.
REQ-009: wr_data  input  1  value written to bit wr_index.
REQ-010: shift_en  input  1  shift/rotate strobe.
REQ-011: shift_dir  input  1  0 = toward MSB (left), 1 = toward LSB (right).
REQ-012: shift_in  input  1  fill bit for shift mode.
REQ-013: rd_index  input  IDX_W  bit position to read.
REQ-014: O  output  1  selected bit of the state register.
REQ-015: value  output  WIDTH  full state register contents.
REQ-016: ones  output  IDX_W+1  registered population count of the state register.

Function
REQ-017: State register S SHALL be WIDTH bits and update only on rising CLK.
REQ-018: O SHALL equal S[rd_index] combinationally (zero-cycle read latency from current S).
REQ-019: rd_index >= WIDTH SHALL drive O = 0.
REQ-020: value SHALL equal S combinationally.
REQ-021: Per-cycle priority: RESET, then shift, then write; the write is applied on top of the shifted value.
REQ-022: shift_en=1, shift_dir=0, ROTATE=0: next S = {S[WIDTH-2:0], shift_in}.
REQ-023: shift_en=1, shift_dir=1, ROTATE=0: next S = {shift_in, S[WIDTH-1:1]}.
REQ-024: ROTATE=1, left: next S = {S[WIDTH-2:0], S[WIDTH-1]}; right: next S = {S[0], S[WIDTH-1:1]}.
REQ-025: wr_en=1 with wr_index < WIDTH: next S[wr_index] = wr_data; all other bits take the shift result (or hold).
REQ-026: wr_en=1 with wr_index >= WIDTH: write SHALL be ignored; shift, if any, still applies.
REQ-027: No strobe asserted: S SHALL hold.
REQ-028: Writes and shifts SHALL be visible on O/value one cycle after the enabling edge.
REQ-029: ones SHALL be a registered popcount of next S, updated on the same edge as S, so ones always equals popcount(value).
REQ-030: Read index SHALL have no side effects; reading during a write returns the pre-edge value.

Reset
REQ-031: RESET=1 at a rising edge SHALL load S = INIT and ones = popcount(INIT) regardless of wr_en/shift_en.
REQ-032: RESET asserted mid-operation SHALL discard any same-cycle write or shift; no partial update.
REQ-033: After reset deassertion, first operation SHALL take effect on the next rising edge.
REQ-034: No output SHALL be X after the first reset edge; O follows rd_index against S = INIT.

Verification (WIDTH=8, INIT=8'hFE unless stated)
REQ-035: Reset, rd_index=0 -> O=0, value=0xFE, ones=7; rd_index=1 -> O=1.
REQ-036: wr_en=1, wr_index=0, wr_data=1 from 0xFE -> next value=0xFF, ones=8; then wr_index=7, wr_data=0 -> 0x7F.
REQ-037: ROTATE=0, shift left shift_in=0 from 0xFE -> 0xFC; shift right shift_in=1 from 0xFE -> 0xFF.
REQ-038: ROTATE=1, rotate left from 0xFE -> 0xFD; rotate right from 0xFE -> 0x7F.
REQ-039: ROTATE=0, shift left shift_in=0 plus wr_index=0, wr_data=1 same cycle from 0xFE -> 0xFD; RESET=1 same cycle with both strobes -> 0xFE.
REQ-040: WIDTH=6, INIT=6'h2A: rd_index=6 or 7 -> O=0; wr_index=7 write ignored, value stays 0x2A, ones=3.
